// File: rtl/w_wb_merge.sv
// Writeback merge: the W pipeline owns the register-file write port and late results
// queue in a small FIFO, retiring in the cycles W leaves idle. Queued entries are killed on a WAW hit.
module w_wb_merge #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned QDEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        w_valid,
   input  logic [1:0]                  w_sel,
   input  logic [ADDR_W-1:0]           w_a3,
   input  logic [DATA_W-1:0]           w_ao,
   input  logic [DATA_W-1:0]           w_dr,
   input  logic [DATA_W-1:0]           w_pc,
   input  logic                        late_valid,
   output logic                        late_ready,
   input  logic [ADDR_W-1:0]           late_a3,
   input  logic [DATA_W-1:0]           late_wd,
   output logic                        rf_we,
   output logic [ADDR_W-1:0]           rf_a3,
   output logic [DATA_W-1:0]           rf_wd,
   output logic [(1<<ADDR_W)-1:0]      pend_mask,
   output logic [$clog2(QDEPTH):0]     q_count
);

   localparam int unsigned PTR_W = $clog2(QDEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned NREG  = 1 << ADDR_W;

   logic [QDEPTH-1:0] ent_valid;
   logic [ADDR_W-1:0] ent_a3 [QDEPTH];
   logic [DATA_W-1:0] ent_wd [QDEPTH];
   logic [PTR_W-1:0]  head, tail;

   logic              w_write, pop, push;
   logic [DATA_W-1:0] w_data;
   logic [QDEPTH-1:0] valid_n;
   logic [PTR_W-1:0]  head_n, tail_n;
   logic [CNT_W-1:0]  count_n;
   logic              we_n;
   logic [ADDR_W-1:0] a3_n;
   logic [DATA_W-1:0] wd_n;
   logic [NREG-1:0]   mask_n;
   logic [ADDR_W-1:0] a3_tmp;

   // Next-state: W write wins the port, otherwise pop the head; kill matching queued entries on W write
   always_comb begin
      w_write = w_valid && (w_a3 != '0);
      case (w_sel)
         2'b01:   w_data = w_dr;
         2'b10:   w_data = w_pc + DATA_W'(8);
         default: w_data = w_ao;
      endcase
      pop  = !w_write && (q_count != '0);
      push = late_valid && late_ready && (late_a3 != '0) && !(w_write && (late_a3 == w_a3));

      valid_n = ent_valid;
      head_n  = head;
      tail_n  = tail;
      we_n    = 1'b0;
      a3_n    = rf_a3;
      wd_n    = rf_wd;
      mask_n  = '0;
      a3_tmp  = '0;

      for (int i = 0; i < int'(QDEPTH); i++) begin
         if (w_write && (ent_a3[i] == w_a3)) valid_n[i] = 1'b0;
      end

      if (w_write) begin
         we_n = 1'b1;
         a3_n = w_a3;
         wd_n = w_data;
      end else if (pop) begin
         we_n          = ent_valid[head];
         a3_n          = ent_a3[head];
         wd_n          = ent_wd[head];
         valid_n[head] = 1'b0;
         head_n        = head + PTR_W'(1);
      end

      if (push) begin
         valid_n[tail] = 1'b1;
         tail_n        = tail + PTR_W'(1);
      end
      count_n = q_count + CNT_W'(push) - CNT_W'(pop);

      // Pending mask from the post-update queue so it lines up with the registered state
      for (int i = 0; i < int'(QDEPTH); i++) begin
         a3_tmp = (push && (tail == PTR_W'(i))) ? late_a3 : ent_a3[i];
         if (valid_n[i]) mask_n[a3_tmp] = 1'b1;
      end
      mask_n[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ent_valid  <= '0;
         head       <= '0;
         tail       <= '0;
         q_count    <= '0;
         rf_we      <= 1'b0;
         rf_a3      <= '0;
         rf_wd      <= '0;
         pend_mask  <= '0;
         late_ready <= 1'b1;
         for (int i = 0; i < int'(QDEPTH); i++) begin
            ent_a3[i] <= '0;
            ent_wd[i] <= '0;
         end
      end else begin
         ent_valid  <= valid_n;
         head       <= head_n;
         tail       <= tail_n;
         q_count    <= count_n;
         rf_we      <= we_n;
         rf_a3      <= a3_n;
         rf_wd      <= wd_n;
         pend_mask  <= mask_n;
         late_ready <= (count_n < CNT_W'(QDEPTH));
         if (push) begin
            ent_a3[tail] <= late_a3;
            ent_wd[tail] <= late_wd;
         end
      end
   end

endmodule

// File: tb/tb_w_wb_merge.sv
// Directed bench for w_wb_merge: W path, zero register, drain, back-pressure, kill, mid-run reset.
module tb_w_wb_merge;

   logic        clk = 1'b0;
   logic        reset;
   logic        w_valid;
   logic [1:0]  w_sel;
   logic [4:0]  w_a3;
   logic [31:0] w_ao, w_dr, w_pc;
   logic        late_valid;
   logic        late_ready;
   logic [4:0]  late_a3;
   logic [31:0] late_wd;
   logic        rf_we;
   logic [4:0]  rf_a3;
   logic [31:0] rf_wd;
   logic [31:0] pend_mask;
   logic [2:0]  q_count;

   int total = 0;
   int bad   = 0;
   logic [31:0] grf9 = 32'h0;

   w_wb_merge dut (
      .clk(clk), .reset(reset),
      .w_valid(w_valid), .w_sel(w_sel), .w_a3(w_a3), .w_ao(w_ao), .w_dr(w_dr), .w_pc(w_pc),
      .late_valid(late_valid), .late_ready(late_ready), .late_a3(late_a3), .late_wd(late_wd),
      .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .pend_mask(pend_mask), .q_count(q_count)
   );

   always #5 clk = ~clk;

   // Shadow of GRF register 9
   always @(posedge clk) if (rf_we && rf_a3 == 5'd9) grf9 <= rf_wd;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      w_valid = 0; w_sel = 2'b00; w_a3 = 0; w_ao = 0; w_dr = 0; w_pc = 0;
      late_valid = 0; late_a3 = 0; late_wd = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1;
      step(); step();
      total++; if (rf_we !== 1'b0)      begin bad++; $display("FAIL reset_we got=%0h exp=0", rf_we); end
      total++; if (rf_a3 !== 5'd0)      begin bad++; $display("FAIL reset_a3 got=%0h exp=0", rf_a3); end
      total++; if (rf_wd !== 32'd0)     begin bad++; $display("FAIL reset_wd got=%0h exp=0", rf_wd); end
      total++; if (q_count !== 3'd0)    begin bad++; $display("FAIL reset_qc got=%0h exp=0", q_count); end
      total++; if (pend_mask !== 32'd0) begin bad++; $display("FAIL reset_mask got=%0h exp=0", pend_mask); end
      total++; if (late_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0h exp=1", late_ready); end
      reset = 0;
      step();
   endtask

   task automatic test_w_path();
      w_valid = 1; w_sel = 2'b10; w_a3 = 31; w_pc = 32'h3000; w_ao = 32'h1234; w_dr = 32'h5678;
      step();
      total++; if (rf_we !== 1'b1)        begin bad++; $display("FAIL wpc_we got=%0h exp=1", rf_we); end
      total++; if (rf_a3 !== 5'd31)       begin bad++; $display("FAIL wpc_a3 got=%0h exp=1f", rf_a3); end
      total++; if (rf_wd !== 32'h3008)    begin bad++; $display("FAIL wpc_wd got=%0h exp=3008", rf_wd); end
      w_sel = 2'b01; w_a3 = 3;
      step();
      total++; if (rf_a3 !== 5'd3 || rf_wd !== 32'h5678) begin bad++; $display("FAIL wdr got=%0h/%0h exp=3/5678", rf_a3, rf_wd); end
      w_sel = 2'b11; w_a3 = 4;
      step();
      total++; if (rf_wd !== 32'h1234)    begin bad++; $display("FAIL wao11 got=%0h exp=1234", rf_wd); end
      w_sel = 2'b10; w_pc = 32'hFFFF_FFFC;
      step();
      total++; if (rf_wd !== 32'h4)       begin bad++; $display("FAIL wpcwrap got=%0h exp=4", rf_wd); end
      idle_inputs();
      step();
      total++; if (rf_we !== 1'b0 || rf_wd !== 32'h4) begin bad++; $display("FAIL idle_hold got=%0h/%0h exp=0/4", rf_we, rf_wd); end
   endtask

   task automatic test_zero_reg();
      w_valid = 1; w_a3 = 0; w_ao = 32'hDEAD;
      late_valid = 1; late_a3 = 0; late_wd = 32'hBEEF;
      step();
      total++; if (rf_we !== 1'b0)      begin bad++; $display("FAIL zero_we got=%0h exp=0", rf_we); end
      total++; if (q_count !== 3'd0)    begin bad++; $display("FAIL zero_qc got=%0h exp=0", q_count); end
      total++; if (late_ready !== 1'b1) begin bad++; $display("FAIL zero_ready got=%0h exp=1", late_ready); end
      // Same-cycle WAW: late result is older and gets dropped
      w_a3 = 5; late_a3 = 5;
      step();
      total++; if (q_count !== 3'd0 || rf_a3 !== 5'd5) begin bad++; $display("FAIL waw_drop got=%0h/%0h exp=0/5", q_count, rf_a3); end
      idle_inputs();
      step();
      total++; if (rf_we !== 1'b0)      begin bad++; $display("FAIL waw_nopop got=%0h exp=0", rf_we); end
   endtask

   task automatic test_drain();
      late_valid = 1; late_a3 = 8; late_wd = 32'hAA;
      step();
      late_valid = 0;
      total++; if (q_count !== 3'd1)        begin bad++; $display("FAIL drain_qc got=%0h exp=1", q_count); end
      total++; if (pend_mask !== 32'h100)   begin bad++; $display("FAIL drain_mask got=%0h exp=100", pend_mask); end
      total++; if (rf_we !== 1'b0)          begin bad++; $display("FAIL drain_nobypass got=%0h exp=0", rf_we); end
      step();
      total++; if (rf_we !== 1'b1 || rf_a3 !== 5'd8 || rf_wd !== 32'hAA)
         begin bad++; $display("FAIL drain_pop got=%0h/%0h/%0h exp=1/8/aa", rf_we, rf_a3, rf_wd); end
      total++; if (pend_mask !== 32'h0 || q_count !== 3'd0)
         begin bad++; $display("FAIL drain_empty got=%0h/%0h exp=0/0", pend_mask, q_count); end
   endtask

   task automatic test_back_pressure();
      logic [2:0] exp_qc [5];
      logic       exp_rdy [5];
      exp_qc  = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
      exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      w_valid = 1; w_sel = 2'b00; w_a3 = 1; w_ao = 32'hF0;
      for (int k = 0; k < 4; k++) begin
         late_valid = 1; late_a3 = 5'(10 + k); late_wd = 32'h100 + 32'(k);
         step();
         total++; if (q_count !== 3'(k + 1) || late_ready !== (k < 3))
            begin bad++; $display("FAIL fill%0d got=%0h/%0h exp=%0h/%0h", k, q_count, late_ready, k + 1, k < 3); end
      end
      total++; if (rf_we !== 1'b1 || rf_a3 !== 5'd1 || rf_wd !== 32'hF0)
         begin bad++; $display("FAIL fill_w got=%0h/%0h/%0h exp=1/1/f0", rf_we, rf_a3, rf_wd); end
      late_a3 = 14; late_wd = 32'h104;
      step();
      total++; if (q_count !== 3'd4 || late_ready !== 1'b0)
         begin bad++; $display("FAIL full_hold got=%0h/%0h exp=4/0", q_count, late_ready); end
      total++; if (pend_mask !== 32'h3C00) begin bad++; $display("FAIL full_mask got=%0h exp=3c00", pend_mask); end
      w_valid = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (k == 1) late_valid = 0;
         total++; if (rf_we !== 1'b1 || rf_a3 !== 5'(10 + k) || rf_wd !== 32'h100 + 32'(k) ||
                      q_count !== exp_qc[k] || late_ready !== exp_rdy[k])
            begin bad++; $display("FAIL retire%0d got=%0h/%0h/%0h/%0h exp=1/%0h/%0h/%0h", k, rf_we, rf_a3, rf_wd, q_count,
                                  10 + k, 32'h100 + 32'(k), exp_qc[k]); end
      end
      idle_inputs();
      step();
   endtask

   task automatic test_kill();
      late_valid = 1; late_a3 = 9; late_wd = 32'h11;
      step();
      late_valid = 0;
      total++; if (pend_mask !== 32'h200) begin bad++; $display("FAIL kill_pre got=%0h exp=200", pend_mask); end
      w_valid = 1; w_sel = 2'b00; w_a3 = 9; w_ao = 32'h22;
      step();
      w_valid = 0;
      total++; if (rf_we !== 1'b1 || rf_a3 !== 5'd9 || rf_wd !== 32'h22)
         begin bad++; $display("FAIL kill_w got=%0h/%0h/%0h exp=1/9/22", rf_we, rf_a3, rf_wd); end
      total++; if (pend_mask !== 32'h0 || q_count !== 3'd1)
         begin bad++; $display("FAIL kill_mask got=%0h/%0h exp=0/1", pend_mask, q_count); end
      step();
      total++; if (rf_we !== 1'b0 || q_count !== 3'd0)
         begin bad++; $display("FAIL kill_pop got=%0h/%0h exp=0/0", rf_we, q_count); end
      step();
      total++; if (grf9 !== 32'h22) begin bad++; $display("FAIL kill_grf9 got=%0h exp=22", grf9); end
   endtask

   task automatic test_reset_mid();
      w_valid = 1; w_sel = 2'b00; w_a3 = 2; w_ao = 32'h77;
      for (int k = 0; k < 3; k++) begin
         late_valid = 1; late_a3 = 5'(20 + k); late_wd = 32'(k);
         step();
      end
      idle_inputs();
      total++; if (q_count !== 3'd3 || rf_we !== 1'b1)
         begin bad++; $display("FAIL mid_pre got=%0h/%0h exp=3/1", q_count, rf_we); end
      #2 reset = 1;
      #1;
      total++; if (rf_we !== 1'b0 || q_count !== 3'd0 || pend_mask !== 32'h0 || late_ready !== 1'b1)
         begin bad++; $display("FAIL mid_reset got=%0h/%0h/%0h/%0h exp=0/0/0/1", rf_we, q_count, pend_mask, late_ready); end
      step();
      reset = 0;
      step(); step();
      total++; if (rf_we !== 1'b0 || q_count !== 3'd0)
         begin bad++; $display("FAIL mid_after got=%0h/%0h exp=0/0", rf_we, q_count); end
   endtask

   initial begin
      test_reset();
      test_w_path();
      test_zero_reg();
      test_drain();
      test_back_pressure();
      test_kill();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
